// File: rtl/serial_fxp_pkg.sv
// Shared types and constants for the serial fixed-point datapath blocks.
package serial_fxp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned DEF_WIDTH = 64;
  localparam int unsigned DEF_FRAC  = 32;

  localparam logic [DEF_WIDTH-1:0] SAT_MAX = {1'b0, {(DEF_WIDTH-1){1'b1}}};
  localparam logic [DEF_WIDTH-1:0] SAT_MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};

endpackage

// File: rtl/fxp_round_sat.sv
// Rescale a signed double-width product by FRAC bits (floor) and saturate to WIDTH bits.
module fxp_round_sat
  import serial_fxp_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned FRAC  = DEF_FRAC
) (
  input  logic [2*WIDTH-1:0] prod,
  output logic [WIDTH-1:0]   p_c,
  output logic               ovf_c
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] LIM_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] LIM_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [PW-1:0] r;
  logic [WIDTH:0] hi;

  // Arithmetic shift floors toward -inf; result fits only if the top WIDTH+1 bits agree.
  always_comb begin
    r     = PW'($signed(prod) >>> FRAC);
    hi    = r[PW-1:WIDTH-1];
    p_c   = r[WIDTH-1:0];
    ovf_c = 1'b0;
    if (!(&hi) && (|hi)) begin
      ovf_c = 1'b1;
      p_c   = r[PW-1] ? LIM_MIN : LIM_MAX;
    end
  end

endmodule

// File: rtl/serial_fixed_mul.sv
// Bit-serial signed fixed-point multiplier with valid/ready operand and result ports.
module serial_fixed_mul
  import serial_fxp_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned FRAC  = DEF_FRAC
) (
  input  logic             clk,
  input  logic             asyn_reset,
  input  logic [WIDTH-1:0] a,
  input  logic             a_vld,
  output logic             a_rdy,
  input  logic [WIDTH-1:0] b,
  input  logic             b_vld,
  output logic             b_rdy,
  output logic [WIDTH-1:0] p,
  output logic             p_vld,
  input  logic             p_rdy,
  output logic             ovf
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t state, state_next;

  logic             got_a, got_b, got_a_next, got_b_next;
  logic             a_take, b_take, start;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    acc, addend, prod;
  logic [WIDTH-1:0] p_c;
  logic             ovf_c;

  // Next-state and handshake decode.
  always_comb begin
    state_next = state;
    a_take     = 1'b0;
    b_take     = 1'b0;
    start      = 1'b0;
    case (state)
      IDLE: begin
        a_take = a_vld && a_rdy;
        b_take = b_vld && b_rdy;
        if ((got_a || a_take) && (got_b || b_take)) begin
          start      = 1'b1;
          state_next = MUL;
        end
      end
      MUL:     if (cnt == CNT_LAST) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    if (p_vld && p_rdy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    got_a_next = start ? 1'b0 : (got_a || a_take);
    got_b_next = start ? 1'b0 : (got_b || b_take);
  end

  // State register.
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) state <= IDLE;
    else            state <= state_next;
  end

  // Registered handshake outputs, derived from next-state so they never see a vld combinationally.
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      got_a <= 1'b0;
      got_b <= 1'b0;
      a_rdy <= 1'b1;
      b_rdy <= 1'b1;
      p_vld <= 1'b0;
    end else begin
      got_a <= got_a_next;
      got_b <= got_b_next;
      a_rdy <= (state_next == IDLE) && !got_a_next;
      b_rdy <= (state_next == IDLE) && !got_b_next;
      p_vld <= (state_next == DONE);
    end
  end

  // Shifted multiplicand for the current multiplier bit, and the signed exact product.
  always_comb begin
    addend = mag_b[cnt] ? (PW'(mag_a) << cnt) : '0;
    prod   = (sign_a ^ sign_b) ? PW'(-acc) : acc;
  end

  // Operand capture, shift-add accumulation and result register.
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      cnt    <= '0;
      acc    <= '0;
      p      <= '0;
      ovf    <= 1'b0;
    end else begin
      if (a_take) begin
        sign_a <= a[WIDTH-1];
        mag_a  <= a[WIDTH-1] ? WIDTH'(-a) : a;
      end
      if (b_take) begin
        sign_b <= b[WIDTH-1];
        mag_b  <= b[WIDTH-1] ? WIDTH'(-b) : b;
      end
      if (start) begin
        acc <= '0;
        cnt <= '0;
      end else if (state == MUL) begin
        acc <= acc + addend;
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
      end
      if (state == FIX) begin
        p   <= p_c;
        ovf <= ovf_c;
      end
    end
  end

  fxp_round_sat #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_round_sat (
    .prod  (prod),
    .p_c   (p_c),
    .ovf_c (ovf_c)
  );

endmodule

// File: tb/tb_serial_fixed_mul.sv
// Self-checking bench for serial_fixed_mul (WIDTH=64, FRAC=32).
module tb_serial_fixed_mul;

  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         asyn_reset = 1'b1;
  logic [W-1:0] a = '0, b = '0;
  logic         a_vld = 1'b0, b_vld = 1'b0, p_rdy = 1'b1;
  logic         a_rdy, b_rdy, p_vld, ovf;
  logic [W-1:0] p;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] p;
    logic         ovf;
  } vec_t;

  vec_t tbl[10];

  serial_fixed_mul #(.WIDTH(64), .FRAC(32)) dut (
    .clk        (clk),
    .asyn_reset (asyn_reset),
    .a          (a),
    .a_vld      (a_vld),
    .a_rdy      (a_rdy),
    .b          (b),
    .b_vld      (b_vld),
    .b_rdy      (b_rdy),
    .p          (p),
    .p_vld      (p_vld),
    .p_rdy      (p_rdy),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: exact signed product, floor-shift by 32, clamp to 64-bit signed range.
  function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                output logic [W-1:0] pe, output logic oe);
    logic signed [127:0] pa, pb, prod, r, lim_hi, lim_lo;
    pa     = $signed({{64{av[63]}}, av});
    pb     = $signed({{64{bv[63]}}, bv});
    prod   = pa * pb;
    r      = prod >>> 32;
    lim_hi = $signed({64'd0, 64'h7FFF_FFFF_FFFF_FFFF});
    lim_lo = -lim_hi - 128'sd1;
    if (r > lim_hi) begin
      pe = 64'h7FFF_FFFF_FFFF_FFFF; oe = 1'b1;
    end else if (r < lim_lo) begin
      pe = 64'h8000_0000_0000_0000; oe = 1'b1;
    end else begin
      pe = r[63:0]; oe = 1'b0;
    end
  endfunction

  // Wait (bounded) for p_vld, returning the number of edges seen since the caller's reference edge.
  task automatic wait_pvld(output int k);
    k = 0;
    while (!p_vld && k < 200) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
  endtask

  // One full transaction with both operands presented together and p_rdy held high.
  task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ep, input logic eo);
    int k;
    @(negedge clk);
    a = av; b = bv; a_vld = 1'b1; b_vld = 1'b1; p_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_vld = 1'b0; b_vld = 1'b0;
    wait_pvld(k);
    check({name, "_latency"}, W'(k), W'(65));
    check({name, "_p"}, p, ep);
    check({name, "_ovf"}, W'(ovf), W'(eo));
    @(posedge clk);
    @(negedge clk);
    check({name, "_rdy_after"}, W'({a_rdy, b_rdy, p_vld}), W'(3'b110));
  endtask

  initial begin
    logic [W-1:0] ep, r0, r1, hold_p;
    logic         eo, hold_ovf, saw_vld;
    int           k;

    tbl[0] = '{64'h0000_0001_8000_0000, 64'h0000_0002_0000_0000, 64'h0000_0003_0000_0000, 1'b0};
    tbl[1] = '{64'hFFFF_FFFE_8000_0000, 64'h0000_0002_0000_0000, 64'hFFFF_FFFD_0000_0000, 1'b0};
    tbl[2] = '{64'hFFFF_FFFE_8000_0000, 64'hFFFF_FFFE_0000_0000, 64'h0000_0003_0000_0000, 1'b0};
    tbl[3] = '{64'h0000_0000_0000_0001, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0000, 1'b0};
    tbl[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    tbl[5] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1};
    tbl[6] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1};
    tbl[7] = '{64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1};
    tbl[8] = '{64'h0000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 1'b0};
    tbl[9] = '{64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_p", p, '0);
    check("reset_flags", W'({ovf, p_vld, a_rdy, b_rdy}), W'(4'b0011));
    asyn_reset = 1'b0;
    @(negedge clk);
    check("post_reset_flags", W'({ovf, p_vld, a_rdy, b_rdy}), W'(4'b0011));

    // Directed table
    for (int i = 0; i < 10; i++)
      run_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].p, tbl[i].ovf);

    // Staggered operands, ignored repeat on a, then back-pressure in DONE
    @(negedge clk);
    a = tbl[0].a; a_vld = 1'b1; b_vld = 1'b0; p_rdy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a = 64'hDEAD_BEEF_1234_5678;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stagger_rdy%0d", i), W'({a_rdy, b_rdy}), W'(2'b01));
      if (i < 4) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    b = tbl[0].b; b_vld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_vld = 1'b0; b_vld = 1'b0;
    wait_pvld(k);
    check("stagger_latency", W'(k), W'(65));
    check("stagger_p", p, tbl[0].p);
    check("stagger_ovf", W'(ovf), '0);
    hold_p = p; hold_ovf = ovf;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bp_p%0d", i), p, hold_p);
      check($sformatf("bp_flags%0d", i), W'({ovf, p_vld, a_rdy, b_rdy}), W'({hold_ovf, 3'b100}));
    end
    p_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release", W'({p_vld, a_rdy, b_rdy}), W'(3'b011));

    // Reset asserted between edges with cnt=20 in MUL
    @(negedge clk);
    a = tbl[5].a; b = tbl[5].b; a_vld = 1'b1; b_vld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_vld = 1'b0; b_vld = 1'b0;
    repeat (20) @(posedge clk);
    #2 asyn_reset = 1'b1;
    #1;
    check("midreset_p", p, '0);
    check("midreset_flags", W'({ovf, p_vld, a_rdy, b_rdy}), W'(4'b0011));
    @(negedge clk);
    asyn_reset = 1'b0;
    saw_vld = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (p_vld) saw_vld = 1'b1;
    end
    check("midreset_no_pvld", W'(saw_vld), '0);
    run_op("after_reset", tbl[1].a, tbl[1].b, tbl[1].p, tbl[1].ovf);

    // Randomized operands against the reference model
    for (int i = 0; i < 24; i++) begin
      r0 = {$urandom, $urandom};
      r1 = {$urandom, $urandom};
      if ($urandom_range(0, 2) != 0) begin
        r0 = {{24{r0[39]}}, r0[39:0]};
        r1 = {{24{r1[39]}}, r1[39:0]};
      end
      model(r0, r1, ep, eo);
      run_op($sformatf("rnd%0d", i), r0, r1, ep, eo);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_fixed_mul.md
# serial_fixed_mul

Bit-serial signed fixed-point multiplier that sits directly downstream of the serial adder/subtractor. It consumes the adder's `sum` as operand `a` and a coefficient `b` through independent valid/ready handshakes. It forms the exact 2·WIDTH-bit signed product with one shift-add step per cycle, rescales by FRAC bits with floor rounding, saturates to WIDTH bits, and presents the result on a valid/ready output.

## Interface
- `WIDTH`, 64: operand and result width, two's complement.
- `FRAC`, 32: number of fractional bits in a, b and p (Q(WIDTH-FRAC).FRAC). Legal range 0 ≤ FRAC < WIDTH.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `asyn_reset`  in  1  reset, asynchronous, active-high.
- `a`  in  WIDTH  operand A (the adder's sum).
- `a_vld`  in  1  A valid.
- `a_rdy`  out  1  A ready.
- `b`  in  WIDTH  operand B.
- `b_vld`  in  1  B valid.
- `b_rdy`  out  1  B ready.
- `p`  out  WIDTH  product, registered.
- `p_vld`  out  1  product valid.
- `p_rdy`  in  1  downstream ready.
- `ovf`  out  1  result saturated; qualified by p_vld.

## Operation
- State machine with four states: IDLE, MUL, FIX, DONE.
- **IDLE**
  - `a_rdy = !got_a` and `b_rdy = !got_b`.
  - A transfer occurs on an edge where vld and rdy are both high. On that edge the operand is captured and its got flag is set.
  - Signs are recorded and magnitudes are stored as WIDTH-bit unsigned values. |−2^(WIDTH−1)| = 2^(WIDTH−1) fits.
  - IDLE→MUL on the edge where the second operand is accepted. If both operands are accepted on the same edge, the transition happens on that edge. Both got flags clear on the transition.
- **MUL**
  - Both rdy outputs are low.
  - Unsigned shift-add: if `mag_b[cnt]` is 1, add `mag_a << cnt` to a 2·WIDTH-bit accumulator. The accumulator is cleared on IDLE→MUL.
  - `cnt` runs 0..WIDTH−1. MUL→FIX on the edge where `cnt == WIDTH−1`.
- **FIX** (one cycle)
  - Negate the accumulator if the operand signs differ, giving the exact signed product P.
  - Compute R = P >>> FRAC (arithmetic shift, i.e. floor toward −∞).
  - If R > 2^(WIDTH−1)−1: register p = 0x7FF…F and ovf = 1.
  - Else if R < −2^(WIDTH−1): register p = 0x800…0 and ovf = 1.
  - Otherwise register p = R[WIDTH−1:0] and ovf = 0.
  - FIX→DONE.
- **DONE**
  - `p_vld = 1`.
  - DONE→IDLE on the edge where p_vld and p_rdy are both high. a_rdy and b_rdy reassert in the following cycle.
- `p` and `ovf` are updated only in FIX and hold otherwise, including across IDLE.

## Timing
- Reset values: state IDLE, got flags 0, cnt 0, accumulator 0, p 0, ovf 0, p_vld 0, a_rdy 1, b_rdy 1.
- Latency: if the completing acceptance edge is E0, p_vld rises after edge E0+WIDTH+1 (WIDTH MUL cycles plus one FIX cycle).
- Throughput: one product per WIDTH+3 cycles at best (IDLE accept, MUL, FIX, DONE).
- Back-pressure: while p_rdy is low in DONE, p, ovf and p_vld hold stable, and a_rdy and b_rdy stay low.
- Staggered operands: an operand that has already been accepted holds its rdy low. A repeated vld on that port is ignored until the next IDLE visit.
- Output rdy and vld depend only on registered state. There is no combinational path from any vld to any rdy.
- Reset mid-operation: asserting asyn_reset in any state returns all registers to their reset values immediately. Any partial product is discarded and no p_vld pulse is produced.

## Structure
- Package `serial_fxp_pkg` contains:
  - the state enum {IDLE, MUL, FIX, DONE}, shared with the serial adder's START/COMP/END encoding style;
  - the default WIDTH and FRAC constants;
  - the saturation-limit constants.
- One sub-module, `fxp_round_sat`: combinational. It takes the 2·WIDTH-bit signed P and outputs WIDTH-bit p and ovf, parameterised by WIDTH and FRAC. The FIX state registers its outputs.
- The top level contains the handshake FSM, operand/sign registers, counter and shift-add datapath.

## Test plan
All scenarios use WIDTH=64, FRAC=32.

- Basic: a=0x0000_0001_8000_0000 (1.5), b=0x0000_0002_0000_0000 (2.0), both valid in the same cycle → p=0x0000_0003_0000_0000, ovf=0, p_vld 65 edges after acceptance.
- Signs: a=−1.5 (0xFFFF_FFFE_8000_0000), b=2.0 → p=0xFFFF_FFFD_0000_0000; a=−1.5, b=−2.0 → p=0x0000_0003_0000_0000.
- Floor rounding:
  - a=0x1, b=0x8000_0000 → p=0x0;
  - a=0xFFFF_FFFF_FFFF_FFFF, b=0x8000_0000 → p=0xFFFF_FFFF_FFFF_FFFF.
- Saturation:
  - a=b=0x7FFF_FFFF_FFFF_FFFF → p=0x7FFF_FFFF_FFFF_FFFF, ovf=1;
  - a=b=0x8000_0000_0000_0000 → p=0x7FFF_FFFF_FFFF_FFFF, ovf=1;
  - a=0x8000…0, b=0x7FFF…F → p=0x8000_0000_0000_0000, ovf=1.
- Handshake:
  - drive a valid 5 cycles before b; check a_rdy drops after a's acceptance while b_rdy stays 1;
  - hold p_rdy low 10 cycles in DONE; check p, ovf and p_vld stable and a_rdy = b_rdy = 0;
  - release p_rdy; check a_rdy = b_rdy = 1 one cycle after the transfer.
- Reset: assert asyn_reset between clock edges at cnt=20 in MUL → all outputs at reset values immediately, no p_vld. The next operand pair then completes correctly.
